lsu_ctrl: RTL and testbench

- Load/store initiator between the RV32I datapath and the word-organised data memory.
- Turns a core byte/half/word load or store into word-aligned memory transactions with per-byte enables.
- Splits misaligned accesses that cross a word boundary into two transactions.
- Returns sign- or zero-extended load data to the core.

---
 rtl/lsu_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Purpose  : RV32I load/store initiator. Converts byte/half/word core
//             accesses into word-aligned memory transactions with byte
//             enables, splitting word-crossing accesses in two, and returns
//             sign/zero-extended load data.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ACC0 = 2'd1;
  localparam logic [1:0] c_ACC1 = 2'd2;
  localparam logic [1:0] c_RESP = 2'd3;

  logic [1:0]        r_state;
  logic              r_we;
  logic [2:0]        r_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rd0;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_req_illegal;
  logic [7:0]        w_base;
  logic [7:0]        w_mask;
  logic              w_split;
  logic [5:0]        w_sh;
  logic [63:0]       w_sd;
  logic [ADDR_W-1:0] w_word0;
  logic [ADDR_W-1:0] w_word1;
  logic [63:0]       w_ld_src;
  logic [31:0]       w_ld32;
  logic [31:0]       w_ld_ext;
  logic [31:0]       w_result;

  // Legality of the incoming request: stores have no unsigned forms
  assign w_req_illegal = req_we ? (req_mode[2] || (req_mode == 3'b011))
                                : ((req_mode == 3'b011) || (req_mode[2:1] == 2'b11));

  // Byte mask of the captured access spread across two consecutive words
  always_comb begin
    case (r_mode[1:0])
      2'b00:   w_base = 8'h01;
      2'b01:   w_base = 8'h03;
      default: w_base = 8'h0F;
    endcase
    w_mask = w_base << r_addr[1:0];
  end

  assign w_split = |w_mask[7:4];
  assign w_sh    = {1'b0, r_addr[1:0], 3'b000};
  assign w_sd    = {32'b0, r_wdata} << w_sh;
  assign w_word0 = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_word1 = w_word0 + ADDR_W'(4);

  // Second phase pairs fresh data with the latched first word
  assign w_ld_src = (r_state == c_ACC1) ? {mem_rdata, r_rd0} : {32'b0, mem_rdata};
  assign w_ld32   = w_ld_src[w_sh +: 32];

  // Sign or zero extension according to funct3
  always_comb begin
    case (r_mode)
      3'b000:  w_ld_ext = {{24{w_ld32[7]}}, w_ld32[7:0]};
      3'b001:  w_ld_ext = {{16{w_ld32[15]}}, w_ld32[15:0]};
      3'b100:  w_ld_ext = {24'b0, w_ld32[7:0]};
      3'b101:  w_ld_ext = {16'b0, w_ld32[15:0]};
      default: w_ld_ext = w_ld32;
    endcase
  end

  assign w_result = r_we ? 32'b0 : w_ld_ext;

  // Outputs decoded from state so memory fields read zero outside a transaction
  assign req_ready  = (r_state == c_IDLE);
  assign resp_valid = (r_state == c_RESP);
  assign mem_req    = (r_state == c_ACC0) || (r_state == c_ACC1);
  assign mem_we     = mem_req && r_we;
  assign mem_be     = (r_state == c_ACC0) ? w_mask[3:0] :
                      (r_state == c_ACC1) ? w_mask[7:4] : 4'b0;
  assign mem_addr   = (r_state == c_ACC0) ? w_word0 :
                      (r_state == c_ACC1) ? w_word1 : '0;
  assign mem_wdata  = (r_state == c_ACC0) ? w_sd[31:0] :
                      (r_state == c_ACC1) ? w_sd[63:32] : 32'b0;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Request capture, transaction sequencing and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
      r_we    <= 1'b0;
      r_mode  <= 3'b0;
      r_addr  <= '0;
      r_wdata <= 32'b0;
      r_rd0   <= 32'b0;
      r_rdata <= 32'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_mode  <= req_mode;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_req_illegal) begin
              r_err   <= 1'b1;
              r_rdata <= 32'b0;
              r_state <= c_RESP;
            end else begin
              r_state <= c_ACC0;
            end
          end
        end
        c_ACC0: begin
          if (mem_ack) begin
            r_rd0 <= mem_rdata;
            if (w_split) begin
              r_state <= c_ACC1;
            end else begin
              r_err   <= 1'b0;
              r_rdata <= w_result;
              r_state <= c_RESP;
            end
          end
        end
        c_ACC1: begin
          if (mem_ack) begin
            r_err   <= 1'b0;
            r_rdata <= w_result;
            r_state <= c_RESP;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Purpose  : Self-checking bench for lsu_ctrl. A byte-addressed memory model
//             answers transactions with programmable wait states; expected
//             transactions and load results are derived byte by byte.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_mode = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'b0;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          wt;
  } tx_t;

  tx_t        exp_q[$];
  logic [7:0] mem_b [logic [31:0]];
  int         n_chk = 0;
  int         n_bad = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem_b[a + 32'(i)] = w[8*i +: 8];
  endtask

  // Memory responder: checks each transaction against the expected queue
  initial begin : responder
    tx_t         cur;
    bit          in_tx;
    int          cnt;
    logic [68:0] snap;
    logic [31:0] word;
    in_tx = 0;
    cnt   = 0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        in_tx     = 0;
      end
      if (!reset_n || !mem_req) begin
        in_tx = 0;
      end else begin
        if (!in_tx) begin
          in_tx = 1;
          if (exp_q.size() == 0) begin
            check_eq("unexpected_mem_req", 96'(mem_req), 96'(0));
            cur = '{addr: mem_addr, be: mem_be, we: mem_we, wdata: mem_wdata, wt: 0};
          end else begin
            cur = exp_q.pop_front();
            check_eq("mem_addr", 96'(mem_addr), 96'(cur.addr));
            check_eq("mem_be", 96'(mem_be), 96'(cur.be));
            check_eq("mem_we", 96'(mem_we), 96'(cur.we));
            if (cur.we) check_eq("mem_wdata", 96'(mem_wdata), 96'(cur.wdata));
          end
          cnt  = cur.wt;
          snap = {mem_addr, mem_be, mem_we, mem_wdata};
        end else begin
          check_eq("mem_stable", 96'({mem_addr, mem_be, mem_we, mem_wdata}), 96'(snap));
        end
        if (cnt == 0) begin
          for (int l = 0; l < 4; l++) word[8*l +: 8] = rd_byte(mem_addr + 32'(l));
          mem_rdata = word;
          mem_ack   = 1'b1;
          if (mem_we)
            for (int l = 0; l < 4; l++)
              if (mem_be[l]) mem_b[mem_addr + 32'(l)] = mem_wdata[8*l +: 8];
        end else begin
          cnt--;
        end
      end
    end
  end

  // Derive expectations from byte-level semantics and drive one request
  task automatic issue(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input int w0, input int w1,
                       output logic [31:0] exp_rd, output logic exp_err, output int exp_n);
    int          size;
    int          off;
    bit          legal;
    bit          split;
    tx_t         t0;
    tx_t         t1;
    logic [31:0] val;
    size  = (mode[1:0] == 2'b00) ? 1 : (mode[1:0] == 2'b01) ? 2 : 4;
    off   = int'(addr[1:0]);
    legal = we ? (mode inside {3'd0, 3'd1, 3'd2}) : (mode inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    split = (off + size) > 4;
    t0 = '{addr: {addr[31:2], 2'b00}, be: 4'b0, we: we, wdata: 32'b0, wt: w0};
    t1 = '{addr: {addr[31:2], 2'b00} + 32'd4, be: 4'b0, we: we, wdata: 32'b0, wt: w1};
    for (int i = 0; i < size; i++) begin
      if (off + i < 4) t0.be[off + i] = 1'b1;
      else             t1.be[off + i - 4] = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      int j;
      j = k - off;
      if (j >= 0 && j < 4) begin
        if (k < 4) t0.wdata[8*k +: 8] = wdata[8*j +: 8];
        else       t1.wdata[8*(k-4) +: 8] = wdata[8*j +: 8];
      end
    end
    val = 32'b0;
    for (int i = 0; i < size; i++) val[8*i +: 8] = rd_byte(addr + 32'(i));
    if (mode == 3'b000) val = {{24{val[7]}}, val[7:0]};
    if (mode == 3'b001) val = {{16{val[15]}}, val[15:0]};
    exp_rd  = (legal && !we) ? val : 32'b0;
    exp_err = !legal;
    exp_n   = !legal ? 1 : (split ? 3 + w0 + w1 : 2 + w0);
    if (legal) begin
      exp_q.push_back(t0);
      if (split) exp_q.push_back(t1);
    end
    @(negedge clk);
    check_eq("req_ready_idle", 96'(req_ready), 96'(1));
    req_valid = 1'b1;
    req_we    = we;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_mode  = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic do_req(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input int w0, input int w1,
                        output logic [31:0] got);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_n;
    int          n;
    issue(we, mode, addr, wdata, w0, w1, exp_rd, exp_err, exp_n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      check_eq("req_ready_busy", 96'(req_ready), 96'(0));
      if (resp_valid) break;
      if (n > 100) begin
        check_eq("resp_timeout", 96'(resp_valid), 96'(1));
        break;
      end
    end
    got = resp_rdata;
    check_eq("latency", 96'(n), 96'(exp_n));
    check_eq("resp_rdata", 96'(resp_rdata), 96'(exp_rd));
    check_eq("resp_err", 96'(resp_err), 96'(exp_err));
    check_eq("tx_remaining", 96'(exp_q.size()), 96'(0));
    @(negedge clk);
    check_eq("resp_pulse", 96'(resp_valid), 96'(0));
    check_eq("ready_after", 96'(req_ready), 96'(1));
    check_eq("rdata_hold", 96'(resp_rdata), 96'(exp_rd));
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_ready", 96'(req_ready), 96'(1));
    check_eq("rst_resp_valid", 96'(resp_valid), 96'(0));
    check_eq("rst_resp_err", 96'(resp_err), 96'(0));
    check_eq("rst_resp_rdata", 96'(resp_rdata), 96'(0));
    check_eq("rst_mem_req", 96'(mem_req), 96'(0));
    check_eq("rst_mem_we", 96'(mem_we), 96'(0));
    check_eq("rst_mem_fields", 96'({mem_be, mem_addr, mem_wdata}), 96'(0));
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] got;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_n;
    int          n;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    put_word(32'h10, 32'h8899_AABB);
    put_word(32'h14, 32'h4433_2211);
    put_word(32'h18, 32'h8877_6655);

    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, 0, got);
    check_eq("lw_0x10", 96'(got), 96'(32'h8899_AABB));
    do_req(1'b0, 3'b000, 32'h11, 32'h0, 0, 0, got);
    check_eq("lb_0x11", 96'(got), 96'(32'hFFFF_FFAA));
    do_req(1'b0, 3'b100, 32'h11, 32'h0, 0, 0, got);
    check_eq("lbu_0x11", 96'(got), 96'(32'h0000_00AA));
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 0, 0, got);
    check_eq("lh_0x12", 96'(got), 96'(32'hFFFF_8899));
    do_req(1'b1, 3'b001, 32'h13, 32'h1234, 0, 0, got);
    check_eq("sh_byte13", 96'(rd_byte(32'h13)), 96'(8'h34));
    check_eq("sh_byte14", 96'(rd_byte(32'h14)), 96'(8'h12));
    do_req(1'b0, 3'b010, 32'h16, 32'h0, 3, 3, got);
    check_eq("lw_0x16_split", 96'(got), 96'(32'h6655_4433));
    do_req(1'b0, 3'b011, 32'h20, 32'h0, 0, 0, got);
    do_req(1'b1, 3'b100, 32'h24, 32'hFFFF_FFFF, 0, 0, got);

    // Reset asserted while the second half of a split store is waiting
    issue(1'b1, 3'b010, 32'h1F, 32'hCAFE_F00D, 0, 1000, exp_rd, exp_err, exp_n);
    n = 0;
    while (!(mem_req && mem_addr == 32'h20) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_acc1", 96'(mem_addr), 96'(32'h20));
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    exp_q.delete();
    #2 reset_n = 1'b1;
    check_eq("split_first_half", 96'(rd_byte(32'h1F)), 96'(8'h0D));
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, 0, got);

    for (int r = 0; r < 300; r++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                      : 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
